// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the pipelined RISC-V core.
//   - XLEN datapath width
//   - ResultSrc and ALUControl encodings
//   - ctrl_t: packed decode/execute control word
//   - CTRL_BUBBLE: the all-zero control word loaded on a bubble
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic       wd3_src;
    logic [1:0] result_src;
    logic [2:0] alu_control;
  } ctrl_t;

  // A bubble must not write regfile/memory, redirect, or look like a load.
  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic logic is_load(input logic [1:0] result_src);
    return result_src == RES_MEM;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use detection and stall/flush priority.
// Ports:
//   i_result_src_e, i_valid_e, i_rd_e : current execute-stage instruction
//   i_rs1_d, i_rs2_d                   : decode-stage source registers
//   i_pcsrc_e                          : execute redirect
//   i_hold_e                           : freeze request from execute/memory
//   o_lw_stall                         : raw load-use hazard
//   o_stall_f, o_stall_d, o_flush_d    : fetch/decode control
//   o_bubble                           : load a bubble into ID/EX on this edge
// Priority: hold > redirect > load-use > normal.
module hazard_detect
  import core_pkg::*;
(
  input  logic [1:0] i_result_src_e,
  input  logic       i_valid_e,
  input  logic [4:0] i_rd_e,
  input  logic [4:0] i_rs1_d,
  input  logic [4:0] i_rs2_d,
  input  logic       i_pcsrc_e,
  input  logic       i_hold_e,
  output logic       o_lw_stall,
  output logic       o_stall_f,
  output logic       o_stall_d,
  output logic       o_flush_d,
  output logic       o_bubble
);

  logic w_lw_stall;

  assign w_lw_stall = is_load(i_result_src_e) && i_valid_e && (i_rd_e != 5'd0) &&
                      ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));
  assign o_lw_stall = w_lw_stall;

  always_comb begin
    o_stall_f = 1'b0;
    o_stall_d = 1'b0;
    o_flush_d = 1'b0;
    o_bubble  = 1'b0;
    if (i_hold_e) begin
      o_stall_f = 1'b1;
      o_stall_d = 1'b1;
    end else if (i_pcsrc_e) begin
      // Decode holds a wrong-path instruction; a simultaneous load-use is moot.
      o_flush_d = 1'b1;
      o_bubble  = 1'b1;
    end else if (w_lw_stall) begin
      o_stall_f = 1'b1;
      o_stall_d = 1'b1;
      o_bubble  = 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with hazard control.
// Ports:
//   clk, rst (async, active-high)
//   *D inputs   : decode control word, operands, PC values, register indices
//   PCSrcE      : execute redirect
//   HoldE       : freeze request; E state and counter held
//   *E outputs  : registered execute-stage copies of the D inputs
//   ValidE      : execute slot holds a real instruction
//   StallF/StallD/FlushD : combinational fetch/decode control
//   BubbleCount : wrapping count of bubbles inserted since reset
module id_ex_stage #(
  parameter int XLEN  = core_pkg::XLEN,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             BranchD,
  input  logic             ALUSrcD,
  input  logic             WD3_SrcD,
  input  logic [1:0]       ResultSrcD,
  input  logic [2:0]       ALUControlD,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             PCSrcE,
  input  logic             HoldE,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             JumpE,
  output logic             BranchE,
  output logic             ALUSrcE,
  output logic             WD3_SrcE,
  output logic [1:0]       ResultSrcE,
  output logic [2:0]       ALUControlE,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic             ValidE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic [CNT_W-1:0] BubbleCount
);

  import core_pkg::*;

  ctrl_t            w_ctrl_d;
  ctrl_t            r_ctrl_e;
  logic [XLEN-1:0]  r_rd1_e;
  logic [XLEN-1:0]  r_rd2_e;
  logic [XLEN-1:0]  r_pc_e;
  logic [XLEN-1:0]  r_imm_e;
  logic [XLEN-1:0]  r_pc4_e;
  logic [4:0]       r_rs1_e;
  logic [4:0]       r_rs2_e;
  logic [4:0]       r_rd_e;
  logic             r_valid_e;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic             w_lw_stall;
  logic             w_bubble;

  assign w_ctrl_d = {RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, WD3_SrcD,
                     ResultSrcD, ALUControlD};

  hazard_detect u_hazard_detect (
    .i_result_src_e (r_ctrl_e.result_src),
    .i_valid_e      (r_valid_e),
    .i_rd_e         (r_rd_e),
    .i_rs1_d        (Rs1D),
    .i_rs2_d        (Rs2D),
    .i_pcsrc_e      (PCSrcE),
    .i_hold_e       (HoldE),
    .o_lw_stall     (w_lw_stall),
    .o_stall_f      (StallF),
    .o_stall_d      (StallD),
    .o_flush_d      (FlushD),
    .o_bubble       (w_bubble)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl_e     <= CTRL_BUBBLE;
      r_rd1_e      <= '0;
      r_rd2_e      <= '0;
      r_pc_e       <= '0;
      r_imm_e      <= '0;
      r_pc4_e      <= '0;
      r_rs1_e      <= '0;
      r_rs2_e      <= '0;
      r_rd_e       <= '0;
      r_valid_e    <= 1'b0;
      r_bubble_cnt <= '0;
    end else if (!HoldE) begin
      if (w_bubble) begin
        r_ctrl_e     <= CTRL_BUBBLE;
        r_rd1_e      <= '0;
        r_rd2_e      <= '0;
        r_pc_e       <= '0;
        r_imm_e      <= '0;
        r_pc4_e      <= '0;
        r_rs1_e      <= '0;
        r_rs2_e      <= '0;
        r_rd_e       <= '0;
        r_valid_e    <= 1'b0;
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end else begin
        r_ctrl_e  <= w_ctrl_d;
        r_rd1_e   <= RD1D;
        r_rd2_e   <= RD2D;
        r_pc_e    <= PCD;
        r_imm_e   <= ImmExtD;
        r_pc4_e   <= PCPlus4D;
        r_rs1_e   <= Rs1D;
        r_rs2_e   <= Rs2D;
        r_rd_e    <= RdD;
        r_valid_e <= 1'b1;
      end
    end
  end

  assign RegWriteE   = r_ctrl_e.reg_write;
  assign MemWriteE   = r_ctrl_e.mem_write;
  assign JumpE       = r_ctrl_e.jump;
  assign BranchE     = r_ctrl_e.branch;
  assign ALUSrcE     = r_ctrl_e.alu_src;
  assign WD3_SrcE    = r_ctrl_e.wd3_src;
  assign ResultSrcE  = r_ctrl_e.result_src;
  assign ALUControlE = r_ctrl_e.alu_control;
  assign RD1E        = r_rd1_e;
  assign RD2E        = r_rd2_e;
  assign PCE         = r_pc_e;
  assign ImmExtE     = r_imm_e;
  assign PCPlus4E    = r_pc4_e;
  assign Rs1E        = r_rs1_e;
  assign Rs2E        = r_rs2_e;
  assign RdE         = r_rd_e;
  assign ValidE      = r_valid_e;
  assign BubbleCount = r_bubble_cnt;

  // Raw load-use flag is only consumed through the priority-resolved outputs.
  logic w_unused;
  assign w_unused = w_lw_stall;

endmodule
